// File: rtl/npc_branch_unit.sv
// PC register and next-PC sequencer for the multi-cycle MIPS datapath.
// Handles PC+4 advance, conditional branches with a fixed condition latency, J/JR redirects.
//
// state | meaning
// IDLE  | accepts jr_req > j_req > br_req > pc_inc, one action per cycle
// EVAL  | branch in flight; counts down, samples cond at terminal count
module npc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          COND_LAT = 1,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_inc,
  input  logic             br_req,
  input  logic [15:0]      br_off,
  input  logic             br_inv,
  input  logic             cond,
  input  logic             j_req,
  input  logic [25:0]      j_index,
  input  logic             jr_req,
  input  logic [31:0]      jr_addr,
  output logic [31:0]      pc_o,
  output logic [31:0]      npc_o,
  output logic             busy,
  output logic             redirect,
  output logic             misalign,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {IDLE, EVAL} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(COND_LAT - 1);

  state_t      state;
  logic [3:0]  eval_cnt;
  logic [15:0] off_q;
  logic        inv_q;

  logic [31:0] pc_seq;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic        taken;
  logic        eval_done;

  // Branch base is the link address captured at the last fetch, not the live PC.
  assign pc_seq    = pc_o + 32'd4;
  assign br_target = npc_o + {{14{off_q[15]}}, off_q, 2'b00};
  assign j_target  = {npc_o[31:28], j_index, 2'b00};
  assign jr_target = {jr_addr[31:2], 2'b00};
  assign taken     = cond ^ inv_q;
  assign eval_done = (eval_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_o      <= RESET_PC;
      npc_o     <= RESET_PC;
      busy      <= 1'b0;
      redirect  <= 1'b0;
      misalign  <= 1'b0;
      br_cnt    <= '0;
      taken_cnt <= '0;
      off_q     <= '0;
      inv_q     <= 1'b0;
      eval_cnt  <= '0;
    end else begin
      redirect <= 1'b0;
      case (state)
        IDLE: begin
          if (jr_req) begin
            pc_o     <= jr_target;
            redirect <= 1'b1;
            misalign <= misalign | (jr_addr[1:0] != 2'b00);
          end else if (j_req) begin
            pc_o     <= j_target;
            redirect <= 1'b1;
          end else if (br_req) begin
            off_q    <= br_off;
            inv_q    <= br_inv;
            eval_cnt <= LAT_LOAD;
            state    <= EVAL;
            busy     <= 1'b1;
          end else if (pc_inc) begin
            pc_o  <= pc_seq;
            npc_o <= pc_seq;
          end
        end
        EVAL: begin
          if (!eval_done) begin
            eval_cnt <= eval_cnt - 4'd1;
          end else begin
            br_cnt    <= br_cnt + CNT_W'(1);
            taken_cnt <= taken_cnt + CNT_W'(taken);
            if (taken) begin
              pc_o     <= br_target;
              redirect <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_branch_unit.sv
// Directed bench for npc_branch_unit: one instance with COND_LAT=1, one with
// COND_LAT=3 and 2-bit counters for latency, EVAL-ignore and wrap cases.
module tb_npc_branch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        pc_inc, br_req, br_inv, cond, j_req, jr_req;
  logic [15:0] br_off;
  logic [25:0] j_index;
  logic [31:0] jr_addr;
  logic [31:0] pc_o, npc_o;
  logic        busy, redirect, misalign;
  logic [15:0] br_cnt, taken_cnt;

  logic        d3_pc_inc, d3_br_req, d3_br_inv, d3_cond, d3_j_req, d3_jr_req;
  logic [15:0] d3_br_off;
  logic [25:0] d3_j_index;
  logic [31:0] d3_jr_addr;
  logic [31:0] d3_pc_o, d3_npc_o;
  logic        d3_busy, d3_redirect, d3_misalign;
  logic [1:0]  d3_br_cnt, d3_taken_cnt;

  int n_cmp = 0;
  int n_err = 0;

  npc_branch_unit #(.RESET_PC(32'h0000_3000), .COND_LAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .br_req(br_req), .br_off(br_off),
    .br_inv(br_inv), .cond(cond), .j_req(j_req), .j_index(j_index), .jr_req(jr_req),
    .jr_addr(jr_addr), .pc_o(pc_o), .npc_o(npc_o), .busy(busy), .redirect(redirect),
    .misalign(misalign), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  npc_branch_unit #(.RESET_PC(32'h0000_3000), .COND_LAT(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pc_inc(d3_pc_inc), .br_req(d3_br_req), .br_off(d3_br_off),
    .br_inv(d3_br_inv), .cond(d3_cond), .j_req(d3_j_req), .j_index(d3_j_index),
    .jr_req(d3_jr_req), .jr_addr(d3_jr_addr), .pc_o(d3_pc_o), .npc_o(d3_npc_o),
    .busy(d3_busy), .redirect(d3_redirect), .misalign(d3_misalign),
    .br_cnt(d3_br_cnt), .taken_cnt(d3_taken_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {pc_inc, br_req, br_inv, cond, j_req, jr_req} = '0;
    br_off = '0; j_index = '0; jr_addr = '0;
    {d3_pc_inc, d3_br_req, d3_br_inv, d3_cond, d3_j_req, d3_jr_req} = '0;
    d3_br_off = '0; d3_j_index = '0; d3_jr_addr = '0;

    #12;
    chk("rst_pc", pc_o, 32'h3000);
    chk("rst_npc", npc_o, 32'h3000);
    chk("rst_busy", busy, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_br_cnt", br_cnt, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    rst_n = 1'b1;

    // two fetches
    pc_inc = 1'b1;
    tick();
    chk("inc1_pc", pc_o, 32'h3004);
    chk("inc1_redirect", redirect, 0);
    tick();
    chk("inc2_pc", pc_o, 32'h3008);
    chk("inc2_npc", npc_o, 32'h3008);
    chk("inc2_redirect", redirect, 0);
    pc_inc = 1'b0;

    // taken backward branch, offset -2 words
    br_req = 1'b1; br_off = 16'hFFFE; br_inv = 1'b0; cond = 1'b1;
    tick();
    br_req = 1'b0;
    chk("br1_busy", busy, 1);
    chk("br1_pc_hold", pc_o, 32'h3008);
    tick();
    chk("br1_pc", pc_o, 32'h3000);
    chk("br1_busy_done", busy, 0);
    chk("br1_redirect", redirect, 1);
    chk("br1_br_cnt", br_cnt, 1);
    chk("br1_taken_cnt", taken_cnt, 1);
    chk("br1_npc", npc_o, 32'h3008);
    tick();
    chk("br1_redirect_end", redirect, 0);

    // aligned JR back to 0x3008
    jr_req = 1'b1; jr_addr = 32'h0000_3008;
    tick();
    jr_req = 1'b0;
    chk("jr0_pc", pc_o, 32'h3008);
    chk("jr0_misalign", misalign, 0);
    tick();

    // inverted condition, not taken
    br_req = 1'b1; br_off = 16'hFFFE; br_inv = 1'b1; cond = 1'b1;
    tick();
    br_req = 1'b0;
    chk("br2_busy", busy, 1);
    tick();
    chk("br2_pc", pc_o, 32'h3008);
    chk("br2_redirect", redirect, 0);
    chk("br2_br_cnt", br_cnt, 2);
    chk("br2_taken_cnt", taken_cnt, 1);
    br_inv = 1'b0; cond = 1'b0;

    // jr beats j and pc_inc; misaligned target
    jr_req = 1'b1; j_req = 1'b1; pc_inc = 1'b1; jr_addr = 32'h0040_0006; j_index = 26'h3FF_FFFF;
    tick();
    {jr_req, j_req, pc_inc} = '0;
    chk("jr1_pc", pc_o, 32'h0040_0004);
    chk("jr1_misalign", misalign, 1);
    chk("jr1_redirect", redirect, 1);
    chk("jr1_npc", npc_o, 32'h3008);

    j_req = 1'b1; j_index = 26'h100;
    tick();
    j_req = 1'b0;
    chk("j1_pc", pc_o, 32'h0000_0400);
    chk("j1_redirect", redirect, 1);
    chk("j1_misalign_sticky", misalign, 1);
    tick();
    chk("j1_redirect_end", redirect, 0);
    chk("idle_misalign_sticky", misalign, 1);

    // COND_LAT=3 instance: requests during EVAL ignored, PC moves at k+3
    d3_br_req = 1'b1; d3_br_off = 16'h0004; d3_cond = 1'b1; d3_pc_inc = 1'b1;
    tick();
    d3_br_req = 1'b0; d3_j_req = 1'b1; d3_j_index = 26'h0AB_CDEF;
    chk("d3_k_busy", d3_busy, 1);
    chk("d3_k_pc", d3_pc_o, 32'h3000);
    tick();
    chk("d3_k1_pc", d3_pc_o, 32'h3000);
    chk("d3_k1_busy", d3_busy, 1);
    tick();
    chk("d3_k2_pc", d3_pc_o, 32'h3000);
    chk("d3_k2_busy", d3_busy, 1);
    chk("d3_k2_br_cnt", d3_br_cnt, 0);
    tick();
    d3_pc_inc = 1'b0; d3_j_req = 1'b0;
    chk("d3_k3_pc", d3_pc_o, 32'h3010);
    chk("d3_k3_busy", d3_busy, 0);
    chk("d3_k3_redirect", d3_redirect, 1);
    chk("d3_k3_npc", d3_npc_o, 32'h3000);
    chk("d3_k3_br_cnt", d3_br_cnt, 1);

    // three more taken zero-offset branches wrap the 2-bit counters
    d3_br_off = 16'h0000;
    for (int b = 0; b < 3; b++) begin
      d3_br_req = 1'b1;
      tick();
      d3_br_req = 1'b0;
      tick(); tick(); tick();
    end
    chk("d3_wrap_pc", d3_pc_o, 32'h3000);
    chk("d3_wrap_br_cnt", d3_br_cnt, 0);
    chk("d3_wrap_taken_cnt", d3_taken_cnt, 0);

    // PC wraps modulo 2^32
    d3_jr_req = 1'b1; d3_jr_addr = 32'hFFFF_FFFC;
    tick();
    d3_jr_req = 1'b0; d3_pc_inc = 1'b1;
    tick();
    d3_pc_inc = 1'b0;
    chk("d3_pcwrap_pc", d3_pc_o, 32'h0);
    chk("d3_pcwrap_npc", d3_npc_o, 32'h0);

    // reset in the middle of a branch
    br_req = 1'b1; br_off = 16'h0010; cond = 1'b1;
    tick();
    br_req = 1'b0;
    chk("rsteval_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("rsteval_pc", pc_o, 32'h3000);
    chk("rsteval_busy0", busy, 0);
    chk("rsteval_br_cnt", br_cnt, 0);
    chk("rsteval_taken_cnt", taken_cnt, 0);
    chk("rsteval_misalign", misalign, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_pc", pc_o, 32'h3000);
    chk("post_rst_redirect", redirect, 0);
    chk("post_rst_br_cnt", br_cnt, 0);
    chk("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
